alu_seq_issuer: RTL and testbench

- Upstream command sequencer for the 16-bit multi-cycle ALU.
- Accepts (a, b, op) commands on a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU using a single-cycle start pulse, then holds the operands until the ALU's done pulse.
- Returns each result, with an error flag, on a valid/ready response interface.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_issuer_fifo.sv | 48 ++++
 rtl/alu_seq_issuer.sv | 147 ++++++++++++++
 tb/tb_alu_seq_issuer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU command sequencer.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_NOR = 3'd4,
      OP_XOR = 3'd5
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      RESP
   } seq_state_t;

   // Codes above XOR (6 and 7) have no ALU operation behind them.
   function automatic logic op_legal(input logic [2:0] op);
      return op <= 3'(OP_XOR);
   endfunction

endpackage

// File: rtl/alu_seq_issuer_fifo.sv
// Command FIFO (module sync_fifo): power-of-two depth, simultaneous push and pop honoured even when full.
module sync_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/alu_seq_issuer.sv
// Buffers ALU commands, issues them one at a time with a start pulse and returns results.
// Optional ALU_SEQ_TIMEOUT_EN adds a WAIT_DONE watchdog that flags a timeout error.
module alu_seq_issuer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH          = 16,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [2:0]       cmd_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   output logic             alu_start,
   input  logic             alu_done,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic             busy
);

   localparam int FW = 2*WIDTH + 3;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("alu_seq_issuer: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
   end

   seq_state_t       state;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic [FW-1:0]    fifo_dout;
   logic [2:0]       head_op;
   logic [WIDTH-1:0] head_a;
   logic [WIDTH-1:0] head_b;

   // cmd_ready stays low while reset is held so nothing is accepted during reset.
   assign cmd_ready = reset && !fifo_full;
   assign fifo_push = cmd_valid && cmd_ready;
   assign fifo_pop  = (state == IDLE) && !fifo_empty;
   assign busy      = !fifo_empty || (state != IDLE);
   assign {head_op, head_a, head_b} = fifo_dout;

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({cmd_op, cmd_a, cmd_b}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] to_cnt;
   logic          to_hit;

   // to_hit marks the cycle whose increment would reach TIMEOUT_CYCLES.
   assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         to_cnt <= '0;
      end else if (state == ISSUE) begin
         to_cnt <= '0;
      end else if (state == WAIT_DONE) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`endif

   // alu_a/alu_b/alu_op double as the held command and are only loaded for legal ops.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         alu_start <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         alu_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  if (op_legal(head_op)) begin
                     alu_a     <= head_a;
                     alu_b     <= head_b;
                     alu_op    <= head_op;
                     alu_start <= 1'b1;
                     state     <= ISSUE;
                  end else begin
                     rsp_data  <= '0;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end
               end
            end
            ISSUE: begin
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (alu_done) begin
                  rsp_data  <= alu_result;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
`ifdef ALU_SEQ_TIMEOUT_EN
               else if (to_hit) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
`endif
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_issuer.sv
// Directed bench for alu_seq_issuer with a behavioural multi-cycle ALU attached.
module tb_alu_seq_issuer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_a = '0;
   logic [15:0] cmd_b = '0;
   logic [2:0]  cmd_op = '0;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [2:0]  alu_op;
   logic        alu_start;
   logic        alu_done;
   logic [15:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int alu_lat = 3;
   bit model_en = 1'b1;
   int start_cnt = 0;
   int unstable = 0;

   alu_seq_issuer #(
      .WIDTH          (16),
      .DEPTH          (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_op     (cmd_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_start  (alu_start),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (alu_start) start_cnt <= start_cnt + 1;

   function automatic logic [15:0] alu_f(input logic [15:0] a, b, input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return ~(a | b);
         3'd5:    return a ^ b;
         default: return 16'h0;
      endcase
   endfunction

   // Multi-cycle ALU: samples on start, answers after alu_lat cycles, aborts on reset.
   initial begin : alu_model
      logic [15:0] ma, mb;
      logic [2:0]  mop;
      int          k;
      alu_done = 1'b0;
      alu_result = '0;
      forever begin
         @(posedge clock); #1;
         if (alu_start && model_en && reset) begin
            ma = alu_a; mb = alu_b; mop = alu_op; k = 0;
            while (k < alu_lat && reset) begin
               @(posedge clock); #1;
               if (reset && {alu_a, alu_b, alu_op} !== {ma, mb, mop}) unstable++;
               k++;
            end
            if (reset) begin
               alu_result = alu_f(ma, mb, mop);
               alu_done = 1'b1;
               @(posedge clock); #1;
               alu_done = 1'b0;
               alu_result = '0;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [15:0] a, b, input logic [2:0] op, output logic acc);
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      acc = cmd_ready;
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic take_rsp(input int budget, output logic got, output logic [15:0] d, output logic e);
      got = 1'b0; d = '0; e = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         if (rsp_valid) begin
            got = 1'b1; d = rsp_data; e = rsp_err;
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      checks++;
      if ({cmd_ready, alu_start, rsp_valid, busy, alu_a, rsp_data, rsp_err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got rdy=%b start=%b vld=%b busy=%b a=%h d=%h e=%b expected all 0",
                  cmd_ready, alu_start, rsp_valid, busy, alu_a, rsp_data, rsp_err);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
      end
      @(negedge clock);
   endtask

   task automatic test_add();
      logic acc, got, e;
      logic [15:0] d;
      int s0;
      s0 = start_cnt;
      push(16'h0003, 16'h0004, 3'd0, acc);
      checks++;
      if (acc !== 1'b1) begin failures++; $display("FAIL add_accept: got %b expected 1", acc); end
      checks++;
      if (alu_start !== 1'b0) begin failures++; $display("FAIL add_start_early: got %b expected 0", alu_start); end
      @(negedge clock);
      checks++;
      if ({alu_start, alu_a, alu_b, alu_op} !== {1'b1, 16'h0003, 16'h0004, 3'd0}) begin
         failures++;
         $display("FAIL add_issue: got start=%b a=%h b=%h op=%0d expected 1 0003 0004 0",
                  alu_start, alu_a, alu_b, alu_op);
      end
      take_rsp(30, got, d, e);
      checks++;
      if ({got, d, e} !== {1'b1, 16'h0007, 1'b0}) begin
         failures++;
         $display("FAIL add_rsp: got vld=%b data=%h err=%b expected 1 0007 0", got, d, e);
      end
      checks++;
      if (start_cnt - s0 !== 1) begin failures++; $display("FAIL add_start_count: got %0d expected 1", start_cnt - s0); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL add_busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic acc1, acc2, got, e;
      logic [15:0] d;
      int u0;
      u0 = unstable;
      push(16'h0000, 16'h0001, 3'd1, acc1);
      push(16'hFF00, 16'h0FF0, 3'd5, acc2);
      checks++;
      if ({acc1, acc2} !== 2'b11) begin failures++; $display("FAIL b2b_accept: got %b expected 11", {acc1, acc2}); end
      take_rsp(30, got, d, e);
      checks++;
      if ({got, d, e} !== {1'b1, 16'hFFFF, 1'b0}) begin
         failures++;
         $display("FAIL b2b_sub: got vld=%b data=%h err=%b expected 1 ffff 0", got, d, e);
      end
      take_rsp(30, got, d, e);
      checks++;
      if ({got, d, e} !== {1'b1, 16'hF0F0, 1'b0}) begin
         failures++;
         $display("FAIL b2b_xor: got vld=%b data=%h err=%b expected 1 f0f0 0", got, d, e);
      end
      checks++;
      if (unstable - u0 !== 0) begin failures++; $display("FAIL b2b_stable: got %0d changes expected 0", unstable - u0); end
   endtask

   task automatic test_illegal();
      logic acc, got, e;
      logic [15:0] d;
      int s0;
      s0 = start_cnt;
      push(16'h0001, 16'h0002, 3'b110, acc);
      take_rsp(30, got, d, e);
      checks++;
      if ({got, d, e} !== {1'b1, 16'h0000, 1'b1}) begin
         failures++;
         $display("FAIL illegal_rsp: got vld=%b data=%h err=%b expected 1 0000 1", got, d, e);
      end
      checks++;
      if (start_cnt - s0 !== 0) begin failures++; $display("FAIL illegal_no_start: got %0d expected 0", start_cnt - s0); end
      push(16'hF0F0, 16'hFF00, 3'd2, acc);
      take_rsp(30, got, d, e);
      checks++;
      if ({got, d, e} !== {1'b1, 16'hF000, 1'b0}) begin
         failures++;
         $display("FAIL illegal_next_and: got vld=%b data=%h err=%b expected 1 f000 0", got, d, e);
      end
      checks++;
      if (start_cnt - s0 !== 1) begin failures++; $display("FAIL illegal_next_start: got %0d expected 1", start_cnt - s0); end
   endtask

   task automatic test_full();
      logic acc [6];
      logic got, e;
      logic [15:0] d;
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(16'(i + 1), 16'h0010, 3'd0, acc[i]);
      push(16'h0099, 16'h0000, 3'd0, acc[5]);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (acc[i] !== (i < 5)) begin
            failures++;
            $display("FAIL full_accept_%0d: got %b expected %b", i, acc[i], (i < 5));
         end
      end
      repeat (5) @(negedge clock);
      checks++;
      if ({cmd_ready, rsp_valid, rsp_data, busy} !== {1'b0, 1'b1, 16'h0011, 1'b1}) begin
         failures++;
         $display("FAIL full_hold: got rdy=%b vld=%b data=%h busy=%b expected 0 1 0011 1",
                  cmd_ready, rsp_valid, rsp_data, busy);
      end
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         take_rsp(40, got, d, e);
         checks++;
         if ({got, d, e} !== {1'b1, 16'(16'h0011 + i), 1'b0}) begin
            failures++;
            $display("FAIL full_drain_%0d: got vld=%b data=%h err=%b expected 1 %h 0", i, got, d, e, 16'(16'h0011 + i));
         end
      end
      take_rsp(30, got, d, e);
      checks++;
      if (got !== 1'b0) begin failures++; $display("FAIL full_extra_rsp: got %b expected 0", got); end
   endtask

   task automatic test_reset_mid();
      logic acc, got, e;
      logic [15:0] d;
      alu_lat = 10;
      push(16'h0001, 16'h0001, 3'd0, acc);
      push(16'h0002, 16'h0002, 3'd0, acc);
      push(16'h0003, 16'h0003, 3'd0, acc);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_data, rsp_err, busy} !== '0) begin
         failures++;
         $display("FAIL midreset_outputs: got rdy=%b a=%h b=%h op=%0d start=%b vld=%b d=%h e=%b busy=%b expected all 0",
                  cmd_ready, alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_data, rsp_err, busy);
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      checks++;
      if ({cmd_ready, busy} !== 2'b10) begin
         failures++;
         $display("FAIL midreset_release: got rdy=%b busy=%b expected 1 0", cmd_ready, busy);
      end
      @(negedge clock);
      take_rsp(30, got, d, e);
      checks++;
      if (got !== 1'b0) begin failures++; $display("FAIL midreset_no_rsp: got %b expected 0", got); end
      alu_lat = 3;
      push(16'h0005, 16'h0006, 3'd0, acc);
      take_rsp(30, got, d, e);
      checks++;
      if ({got, d, e} !== {1'b1, 16'h000B, 1'b0}) begin
         failures++;
         $display("FAIL midreset_recover: got vld=%b data=%h err=%b expected 1 000b 0", got, d, e);
      end
   endtask

`ifdef ALU_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      logic acc, got, e;
      logic [15:0] d;
      int n;
      model_en = 1'b0;
      push(16'h1234, 16'h0001, 3'd0, acc);
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (n !== 18) begin failures++; $display("FAIL timeout_cycles: got %0d expected 18", n); end
      take_rsp(5, got, d, e);
      checks++;
      if ({got, d, e} !== {1'b1, 16'h0000, 1'b1}) begin
         failures++;
         $display("FAIL timeout_rsp: got vld=%b data=%h err=%b expected 1 0000 1", got, d, e);
      end
      model_en = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_illegal();
      test_full();
      test_reset_mid();
`ifdef ALU_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
